fsa_row_extent: RTL and testbench

//  Downstream consumer of the fsa classification stream. Scans each line of 2-bit

---
 rtl/fsa_row_extent_if.sv | 69 ++++++
 rtl/fsa_row_extent.sv | 204 ++++++++++++++++++++
 tb/tb_fsa_row_extent.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsa_row_extent_if.sv
// fsa_row_extent interfaces.
//
// fsa_axis_if : class-code beat stream into the row-extent scanner.
//   s_axis_tvalid  beat valid
//   s_axis_tdata   {test, class}
//   s_axis_tuser   first beat of frame
//   s_axis_tlast   last beat of line
//   s_axis_tready  scanner can take a beat
//   master = stream producer, slave = scanner.
//
// fsa_rec_if : one result record per line.
//   m_valid / m_ready  record handshake
//   m_row, m_lft, m_rt, m_hit  record fields
//   m_run  longest hit run (only with FSA_EXT_RUNLEN_EN defined)
//   master = scanner, slave = record consumer.

interface fsa_axis_if #(
    parameter int unsigned DW = 14
) ();
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tready;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast,
        input  s_axis_tready
    );
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast,
        output s_axis_tready
    );
endinterface

interface fsa_rec_if #(
    parameter int unsigned HW = 8,
    parameter int unsigned WW = 8
) ();
    logic          m_valid;
    logic          m_ready;
    logic [HW-1:0] m_row;
    logic [WW-1:0] m_lft;
    logic [WW-1:0] m_rt;
    logic          m_hit;
`ifdef FSA_EXT_RUNLEN_EN
    logic [WW-1:0] m_run;
`endif

`ifdef FSA_EXT_RUNLEN_EN
    modport master (
        output m_valid, m_row, m_lft, m_rt, m_hit, m_run,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_row, m_lft, m_rt, m_hit, m_run,
        output m_ready
    );
`else
    modport master (
        output m_valid, m_row, m_lft, m_rt, m_hit,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_row, m_lft, m_rt, m_hit,
        output m_ready
    );
`endif
endinterface

// File: rtl/fsa_row_extent.sv
// fsa_row_extent
//   Consumes the fsa classification stream, finds the leftmost and rightmost
//   column per line whose class equals C_OUT_DV, and emits one record per
//   line over a valid/ready handshake. Also latches a per-frame summary of
//   the first and last row that contained a hit.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   height       rows per frame (0 behaves as 1), sampled on each tlast beat
//   s_axis       fsa_axis_if.slave : class beats in, tready = ~m_valid | m_ready
//   m_rec        fsa_rec_if.master : {m_row, m_lft, m_rt, m_hit[, m_run]}
//   f_done       1-cycle pulse at end of frame
//   f_any        frame had at least one hit row
//   f_top/f_bot  first/last hit row of the finished frame
//
// Optional feature: define FSA_EXT_RUNLEN_EN to add m_run, the longest
// contiguous run of hit columns in the line.

module fsa_row_extent #(
    parameter int unsigned C_TEST   = 12,
    parameter int unsigned C_OUT_DW = 2,
    parameter int unsigned C_OUT_DV = 2,
    parameter int unsigned C_IMG_HW = 8,
    parameter int unsigned C_IMG_WW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [C_IMG_HW-1:0] height,
    fsa_axis_if.slave           s_axis,
    fsa_rec_if.master           m_rec,
    output logic                f_done,
    output logic                f_any,
    output logic [C_IMG_HW-1:0] f_top,
    output logic [C_IMG_HW-1:0] f_bot
);

    localparam logic [C_OUT_DW-1:0] HIT_CLASS = C_OUT_DW'(C_OUT_DV);
    localparam logic [C_IMG_WW-1:0] COL_MAX   = '1;

    // Line / frame state
    logic [C_IMG_WW-1:0] col;
    logic [C_IMG_HW-1:0] row;
    logic                l_hit;
    logic [C_IMG_WW-1:0] l_lft;
    logic [C_IMG_WW-1:0] l_rt;
    logic                fr_any;
    logic [C_IMG_HW-1:0] fr_top;
    logic [C_IMG_HW-1:0] fr_bot;

    // Effective (tuser-adjusted) and next values for the current beat
    logic                beat;
    logic                b_hit;
    logic                end_hit;
    logic                row_last;
    logic [C_IMG_WW-1:0] col_e;
    logic [C_IMG_WW-1:0] col_inc;
    logic [C_IMG_HW-1:0] row_e;
    logic [C_IMG_HW-1:0] row_inc;
    logic [C_IMG_HW-1:0] h_last;
    logic                hit_e;
    logic                hit_n;
    logic [C_IMG_WW-1:0] lft_e;
    logic [C_IMG_WW-1:0] lft_n;
    logic [C_IMG_WW-1:0] rt_e;
    logic [C_IMG_WW-1:0] rt_n;
    logic                any_e;
    logic                any_n;
    logic [C_IMG_HW-1:0] top_e;
    logic [C_IMG_HW-1:0] top_n;
    logic [C_IMG_HW-1:0] bot_e;
    logic [C_IMG_HW-1:0] bot_n;
    logic                unused_test;

`ifdef FSA_EXT_RUNLEN_EN
    logic [C_IMG_WW-1:0] l_cur;
    logic [C_IMG_WW-1:0] l_max;
    logic [C_IMG_WW-1:0] cur_e;
    logic [C_IMG_WW-1:0] cur_n;
    logic [C_IMG_WW-1:0] max_e;
    logic [C_IMG_WW-1:0] max_n;
`endif

    always_comb begin
        s_axis.s_axis_tready = ~m_rec.m_valid | m_rec.m_ready;
    end

    always_comb begin
        unused_test = ^s_axis.s_axis_tdata[C_TEST+C_OUT_DW-1:C_OUT_DW];

        beat  = s_axis.s_axis_tvalid & (~m_rec.m_valid | m_rec.m_ready);
        b_hit = (s_axis.s_axis_tdata[C_OUT_DW-1:0] == HIT_CLASS);

        // A tuser beat starts from a clean slate: partial line and frame
        // accumulation is dropped by substituting zeroes for the registers.
        col_e = s_axis.s_axis_tuser ? '0   : col;
        row_e = s_axis.s_axis_tuser ? '0   : row;
        hit_e = s_axis.s_axis_tuser ? 1'b0 : l_hit;
        lft_e = s_axis.s_axis_tuser ? '0   : l_lft;
        rt_e  = s_axis.s_axis_tuser ? '0   : l_rt;
        any_e = s_axis.s_axis_tuser ? 1'b0 : fr_any;
        top_e = s_axis.s_axis_tuser ? '0   : fr_top;
        bot_e = s_axis.s_axis_tuser ? '0   : fr_bot;

        col_inc = (col_e == COL_MAX) ? col_e : col_e + 1'b1;
        row_inc = row_e + 1'b1;

        hit_n = hit_e | b_hit;
        lft_n = (b_hit & ~hit_e) ? col_e : lft_e;
        rt_n  = b_hit ? col_e : rt_e;

        h_last   = (height == '0) ? '0 : height - 1'b1;
        row_last = (row_e == h_last);

        end_hit = s_axis.s_axis_tlast & hit_n;
        any_n   = any_e | end_hit;
        top_n   = (end_hit & ~any_e) ? row_e : top_e;
        bot_n   = end_hit ? row_e : bot_e;

`ifdef FSA_EXT_RUNLEN_EN
        cur_e = s_axis.s_axis_tuser ? '0 : l_cur;
        max_e = s_axis.s_axis_tuser ? '0 : l_max;
        if (b_hit) begin
            cur_n = (cur_e == COL_MAX) ? cur_e : cur_e + 1'b1;
        end else begin
            cur_n = '0;
        end
        max_n = (cur_n > max_e) ? cur_n : max_e;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col           <= '0;
            row           <= '0;
            l_hit         <= 1'b0;
            l_lft         <= '0;
            l_rt          <= '0;
            fr_any        <= 1'b0;
            fr_top        <= '0;
            fr_bot        <= '0;
            m_rec.m_valid <= 1'b0;
            m_rec.m_row   <= '0;
            m_rec.m_lft   <= '0;
            m_rec.m_rt    <= '0;
            m_rec.m_hit   <= 1'b0;
            f_done        <= 1'b0;
            f_any         <= 1'b0;
            f_top         <= '0;
            f_bot         <= '0;
`ifdef FSA_EXT_RUNLEN_EN
            l_cur         <= '0;
            l_max         <= '0;
            m_rec.m_run   <= '0;
`endif
        end else begin
            f_done        <= 1'b0;
            // A beat is only accepted while the record slot is free or
            // draining, so loading here never overwrites an unread record.
            m_rec.m_valid <= (beat & s_axis.s_axis_tlast) |
                             (m_rec.m_valid & ~m_rec.m_ready);
            if (beat) begin
                fr_any <= any_n;
                fr_top <= top_n;
                fr_bot <= bot_n;
                if (s_axis.s_axis_tlast) begin
                    col         <= '0;
                    row         <= row_last ? '0 : row_inc;
                    l_hit       <= 1'b0;
                    l_lft       <= '0;
                    l_rt        <= '0;
                    m_rec.m_row <= row_e;
                    m_rec.m_lft <= lft_n;
                    m_rec.m_rt  <= rt_n;
                    m_rec.m_hit <= hit_n;
`ifdef FSA_EXT_RUNLEN_EN
                    l_cur       <= '0;
                    l_max       <= '0;
                    m_rec.m_run <= max_n;
`endif
                    if (row_last) begin
                        f_done <= 1'b1;
                        f_any  <= any_n;
                        f_top  <= top_n;
                        f_bot  <= bot_n;
                        fr_any <= 1'b0;
                        fr_top <= '0;
                        fr_bot <= '0;
                    end
                end else begin
                    col   <= col_inc;
                    row   <= row_e;
                    l_hit <= hit_n;
                    l_lft <= lft_n;
                    l_rt  <= rt_n;
`ifdef FSA_EXT_RUNLEN_EN
                    l_cur <= cur_n;
                    l_max <= max_n;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fsa_row_extent.sv
`timescale 1ns/1ps
module tb_fsa_row_extent;

    localparam int unsigned C_TEST   = 12;
    localparam int unsigned C_OUT_DW = 2;
    localparam int unsigned C_OUT_DV = 2;
    localparam int unsigned HW       = 8;
    localparam int unsigned WW       = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [HW-1:0] height = 8'd20;
    logic          f_done;
    logic          f_any;
    logic [HW-1:0] f_top;
    logic [HW-1:0] f_bot;

    fsa_axis_if #(.DW(C_TEST + C_OUT_DW)) s_axis ();
    fsa_rec_if  #(.HW(HW), .WW(WW))       m_rec ();

    fsa_row_extent #(
        .C_TEST   (C_TEST),
        .C_OUT_DW (C_OUT_DW),
        .C_OUT_DV (C_OUT_DV),
        .C_IMG_HW (HW),
        .C_IMG_WW (WW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .height (height),
        .s_axis (s_axis),
        .m_rec  (m_rec),
        .f_done (f_done),
        .f_any  (f_any),
        .f_top  (f_top),
        .f_bot  (f_bot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HW-1:0] row;
        logic [WW-1:0] lft;
        logic [WW-1:0] rt;
        logic [WW-1:0] run;
        logic          hit;
    } rec_t;

    typedef struct packed {
        logic          any;
        logic [HW-1:0] top;
        logic [HW-1:0] bot;
    } frm_t;

    rec_t exp_q[$];
    frm_t frm_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rand_ready = 1'b0;
    bit   rand_gaps  = 1'b0;
    bit   hold_ready = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Test images. Kind 0: hit block rows 5..7, cols 18..22 (40 wide).
    // Kind 1: hits only at cols 0 and 39 of row 2 (40 wide).
    // Kind 2: hits at cols 250..299 (300 wide, exceeds column range).
    function automatic logic [1:0] pix(input int kind, input int r, input int c);
        case (kind)
            0: return (r >= 5 && r <= 7 && c >= 18 && c <= 22) ? 2'b10 : 2'b00;
            1: return (r == 2 && (c == 0 || c == 39)) ? 2'b10 :
                      ((c % 3) == 0 ? 2'b11 : 2'b01);
            2: return (c >= 250) ? 2'b10 : 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int width_of(input int kind);
        return (kind == 2) ? 300 : 40;
    endfunction

    // Hand-computed record expectations for each image line.
    task automatic push_rec(input int dut_row, input int kind, input int r);
        rec_t e;
        e = '0;
        e.row = HW'(dut_row);
        if (kind == 0 && r >= 5 && r <= 7) begin
            e.hit = 1'b1; e.lft = 8'd18; e.rt = 8'd22; e.run = 8'd5;
        end else if (kind == 1 && r == 2) begin
            e.hit = 1'b1; e.lft = 8'd0; e.rt = 8'd39; e.run = 8'd1;
        end else if (kind == 2) begin
            e.hit = 1'b1; e.lft = 8'd250; e.rt = 8'd255; e.run = 8'd50;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_frm(input logic any, input int top, input int bot);
        frm_t f;
        f.any = any;
        f.top = HW'(top);
        f.bot = HW'(bot);
        frm_q.push_back(f);
    endtask

    task automatic send_beat(input logic [1:0] cls, input logic tu, input logic tl);
        int unsigned waitc = 0;
        @(negedge clk);
        s_axis.s_axis_tvalid = 1'b0;
        if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_axis.s_axis_tvalid = 1'b1;
        s_axis.s_axis_tdata  = {C_TEST'($urandom), cls};
        s_axis.s_axis_tuser  = tu;
        s_axis.s_axis_tlast  = tl;
        #1;
        while (!s_axis.s_axis_tready) begin
            waitc++;
            if (waitc > 500) begin
                total++;
                bad++;
                $display("FAIL tready_timeout: got tready=0 for %0d cycles, expected 1", waitc);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 s_axis.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_line(input int kind, input int r, input bit first);
        int w;
        w = width_of(kind);
        for (int c = 0; c < w; c++)
            send_beat(pix(kind, r, c), first && (c == 0), c == w - 1);
    endtask

    task automatic send_frame(input int kind);
        if (kind == 0) push_frm(1'b1, 5, 7);
        else           push_frm(1'b1, 2, 2);
        for (int r = 0; r < 20; r++) begin
            push_rec(r, kind, r);
            send_line(kind, r, r == 0);
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || frm_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pending_records"}, exp_q.size(), 0);
        check({tag, "_pending_frames"}, frm_q.size(), 0);
        exp_q.delete();
        frm_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Record monitor: owns m_ready, pops the scoreboard on each transfer.
    initial begin
        rec_t e;
        m_rec.m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_rec.m_ready = hold_ready ? 1'b0 :
                            (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (!reset && m_rec.m_valid && m_rec.m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rec_unexpected: got record row=%0d, expected none", m_rec.m_row);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_row", m_rec.m_row, e.row);
                    check("rec_hit", m_rec.m_hit, e.hit);
                    check("rec_lft", m_rec.m_lft, e.lft);
                    check("rec_rt",  m_rec.m_rt,  e.rt);
`ifdef FSA_EXT_RUNLEN_EN
                    check("rec_run", m_rec.m_run, e.run);
`endif
                end
            end
        end
    end

    // Frame monitor
    initial begin
        frm_t f;
        forever begin
            @(negedge clk);
            if (!reset && f_done) begin
                if (frm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frm_unexpected: got f_done f_any=%0d, expected no f_done", f_any);
                end else begin
                    f = frm_q.pop_front();
                    check("frm_any", f_any, f.any);
                    if (f.any) begin
                        check("frm_top", f_top, f.top);
                        check("frm_bot", f_bot, f.bot);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.s_axis_tvalid = 1'b0;
        s_axis.s_axis_tdata  = '0;
        s_axis.s_axis_tuser  = 1'b0;
        s_axis.s_axis_tlast  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_m_valid", m_rec.m_valid, 0);
        check("rst_tready",  s_axis.s_axis_tready, 1);
        check("rst_m_row",   m_rec.m_row, 0);
        check("rst_m_hit",   m_rec.m_hit, 0);
        check("rst_f_done",  f_done, 0);
        check("rst_f_any",   f_any, 0);
        check("rst_f_top",   f_top, 0);
        check("rst_f_bot",   f_bot, 0);

        // 1: basic 40x20 frame
        send_frame(0);
        drain("s1");

        // 2: back-pressure after the row-3 record
        push_frm(1'b1, 5, 7);
        for (int r = 0; r < 4; r++) begin
            push_rec(r, 0, r);
            send_line(0, r, r == 0);
        end
        hold_ready = 1'b1;
        @(negedge clk);
        #1;
        check("hold_tready", s_axis.s_axis_tready, 0);
        check("hold_valid",  m_rec.m_valid, 1);
        check("hold_row",    m_rec.m_row, 3);
        push_rec(4, 0, 4);
        fork
            send_line(0, 4, 1'b0);
            begin
                repeat (4) @(negedge clk);
                #1;
                check("hold_row_stable", m_rec.m_row, 3);
                check("hold_valid_stable", m_rec.m_valid, 1);
                check("hold_tready_stable", s_axis.s_axis_tready, 0);
                #1 hold_ready = 1'b0;
            end
        join
        for (int r = 5; r < 20; r++) begin
            push_rec(r, 0, r);
            send_line(0, r, 1'b0);
        end
        drain("s2");

        // 3: frame aborted by tuser at col 12 of row 9
        for (int r = 0; r < 9; r++) begin
            push_rec(r, 0, r);
            send_line(0, r, r == 0);
        end
        for (int c = 0; c < 12; c++)
            send_beat(pix(0, 9, c), 1'b0, 1'b0);
        send_frame(0);
        drain("s3");

        // 4: hits only at the line edges
        send_frame(1);
        drain("s4");

        // 5: reset mid-line, then a fresh frame
        for (int r = 0; r < 6; r++) begin
            push_rec(r, 0, r);
            send_line(0, r, r == 0);
        end
        for (int c = 0; c < 20; c++)
            send_beat(pix(0, 6, c), 1'b0, 1'b0);
        drain("s5a");
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        check("mrst_m_valid", m_rec.m_valid, 0);
        check("mrst_tready",  s_axis.s_axis_tready, 1);
        check("mrst_f_any",   f_any, 0);
        check("mrst_f_top",   f_top, 0);
        check("mrst_f_bot",   f_bot, 0);
        check("mrst_f_done",  f_done, 0);
        #1 reset = 1'b0;
        send_frame(0);
        drain("s5b");

        // 6: random gaps and back-pressure over 3 frames
        rand_ready = 1'b1;
        rand_gaps  = 1'b1;
        send_frame(0);
        send_frame(1);
        send_frame(0);
        drain("s6");
        rand_ready = 1'b0;
        rand_gaps  = 1'b0;

        // height 0 acts as 1: every line is a frame; also column saturation
        height = '0;
        push_rec(0, 0, 5);
        push_frm(1'b1, 0, 0);
        send_line(0, 5, 1'b0);
        push_rec(0, 2, 0);
        push_frm(1'b1, 0, 0);
        send_line(2, 0, 1'b0);
        push_rec(0, 0, 0);
        push_frm(1'b0, 0, 0);
        send_line(0, 0, 1'b0);
        drain("h0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
